// File: rtl/nonce_result_scan_if.sv
// Scan control, result and shared-memory signals for nonce_result_scan.
// The slave modport is the scanner; the master side is whoever starts it and hosts the memory.
interface nonce_result_scan_if;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;
  logic [8:0]  match_count;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  start, hash_addr, result_addr, target, mem_read_data,
    output done, found, best_nonce, best_hash, match_count,
           mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output start, hash_addr, result_addr, target, mem_read_data,
    input  done, found, best_nonce, best_hash, match_count,
           mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES hash words for the minimum and for values below a target,
// then writes a 3-word result record back to the shared memory.
module nonce_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  nonce_result_scan_if.slave bus
);

  localparam logic [8:0] LAST_K   = 9'(NUM_NONCES - 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t      state, state_next;
  logic [8:0]  k, k_next;
  logic [1:0]  w, w_next;
  logic [15:0] result_base, result_base_next;
  logic [31:0] target_q, target_next;
  logic        found_q, found_next;
  logic [7:0]  best_nonce_q, best_nonce_next;
  logic [31:0] best_hash_q, best_hash_next;
  logic [8:0]  match_count_q, match_count_next;
  logic        done_q, done_next;
  logic        we_q, we_next;
  logic [15:0] addr_q, addr_next;
  logic [31:0] wdata_q, wdata_next;

  logic        eval_en;
  logic [7:0]  eval_idx;
  logic        eval_found;
  logic [7:0]  eval_best_nonce;
  logic [31:0] eval_best_hash;
  logic [8:0]  eval_count;

  // Read data lags its address by one cycle, so READ cycle k scores word k-1 and DRAIN scores the last word.
  always_comb begin
    eval_en         = ((state == READ) && (k != 9'd0)) || (state == DRAIN);
    eval_idx        = (state == DRAIN) ? LAST_IDX : 8'(k - 9'd1);
    eval_found      = found_q;
    eval_best_nonce = best_nonce_q;
    eval_best_hash  = best_hash_q;
    eval_count      = match_count_q;
    if (eval_en) begin
      if (bus.mem_read_data < best_hash_q) begin
        eval_best_hash  = bus.mem_read_data;
        eval_best_nonce = eval_idx;
      end
      if (bus.mem_read_data < target_q) begin
        eval_count = match_count_q + 9'd1;
        eval_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state;
    k_next           = k;
    w_next           = w;
    result_base_next = result_base;
    target_next      = target_q;
    found_next       = eval_found;
    best_nonce_next  = eval_best_nonce;
    best_hash_next   = eval_best_hash;
    match_count_next = eval_count;
    done_next        = done_q;
    we_next          = we_q;
    addr_next        = addr_q;
    wdata_next       = wdata_q;

    case (state)
      IDLE: begin
        done_next = 1'b1;
        we_next   = 1'b0;
        addr_next = 16'h0000;
        if (bus.start) begin
          state_next       = READ;
          done_next        = 1'b0;
          addr_next        = bus.hash_addr;
          result_base_next = bus.result_addr;
          target_next      = bus.target;
          best_hash_next   = 32'hFFFF_FFFF;
          best_nonce_next  = 8'd0;
          found_next       = 1'b0;
          match_count_next = 9'd0;
          k_next           = 9'd0;
        end
      end
      READ: begin
        k_next    = k + 9'd1;
        addr_next = addr_q + 16'd1;
        if (k == LAST_K) begin
          state_next = DRAIN;
          addr_next  = addr_q;
        end
      end
      DRAIN: begin
        // The first record word must already include the last word's evaluation.
        state_next = WRITE;
        w_next     = 2'd0;
        we_next    = 1'b1;
        addr_next  = result_base;
        wdata_next = {23'b0, eval_found, eval_best_nonce};
      end
      WRITE: begin
        w_next    = w + 2'd1;
        addr_next = addr_q + 16'd1;
        case (w)
          2'd0:    wdata_next = best_hash_q;
          2'd1:    wdata_next = {23'b0, match_count_q};
          default: begin
            state_next = IDLE;
            we_next    = 1'b0;
            addr_next  = 16'h0000;
            done_next  = 1'b1;
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      k             <= 9'd0;
      w             <= 2'd0;
      result_base   <= 16'h0000;
      target_q      <= 32'h0000_0000;
      found_q       <= 1'b0;
      best_nonce_q  <= 8'd0;
      best_hash_q   <= 32'hFFFF_FFFF;
      match_count_q <= 9'd0;
      done_q        <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 32'h0000_0000;
    end else begin
      state         <= state_next;
      k             <= k_next;
      w             <= w_next;
      result_base   <= result_base_next;
      target_q      <= target_next;
      found_q       <= found_next;
      best_nonce_q  <= best_nonce_next;
      best_hash_q   <= best_hash_next;
      match_count_q <= match_count_next;
      done_q        <= done_next;
      we_q          <= we_next;
      addr_q        <= addr_next;
      wdata_q       <= wdata_next;
    end
  end

  assign bus.mem_clk        = clk;
  assign bus.done           = done_q;
  assign bus.found          = found_q;
  assign bus.best_nonce     = best_nonce_q;
  assign bus.best_hash      = best_hash_q;
  assign bus.match_count    = match_count_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_nonce_result_scan.sv
// Directed bench for nonce_result_scan: a behavioural memory supplies hash words and
// logs every record write; each task checks its own scenario against hand-computed values.
module tb_nonce_result_scan;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nonce_result_scan_if bus();

  nonce_result_scan #(.NUM_NONCES(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [31:0] mem [0:65535];
  logic [15:0] wlog_addr [0:255];
  logic [31:0] wlog_data [0:255];
  logic [15:0] addr_log [0:127];
  int write_count = 0;
  int checks = 0;
  int fails = 0;

  // Memory writes are only logged so the bench alone fills the array.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      wlog_addr[8'(write_count)] <= bus.mem_addr;
      wlog_data[8'(write_count)] <= bus.mem_write_data;
      write_count <= write_count + 1;
    end
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tgt,
                          input bit pulse, output int cycles);
    bus.hash_addr = ha; bus.result_addr = ra; bus.target = tgt; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hash_addr = 16'h1234; bus.result_addr = 16'h4321; bus.target = 32'h0;
    cycles = 0;
    addr_log[0] = bus.mem_addr;
    while (bus.done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      addr_log[cycles] = bus.mem_addr;
      bus.start = pulse && (cycles == 5 || cycles == 18);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.hash_addr = 16'h0; bus.result_addr = 16'h0; bus.target = 32'h0;
    reset_n = 1'b0;
    #12;
    checks++; if (bus.done !== 1'b1) begin fails++; $display("[TB] FAIL rst_done: got %h expected 1", bus.done); end
    checks++; if (bus.mem_we !== 1'b0) begin fails++; $display("[TB] FAIL rst_we: got %h expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 16'h0) begin fails++; $display("[TB] FAIL rst_addr: got %h expected 0000", bus.mem_addr); end
    checks++; if (bus.mem_write_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_wdata: got %h expected 0", bus.mem_write_data); end
    checks++; if (bus.found !== 1'b0) begin fails++; $display("[TB] FAIL rst_found: got %h expected 0", bus.found); end
    checks++; if (bus.best_nonce !== 8'd0) begin fails++; $display("[TB] FAIL rst_nonce: got %h expected 00", bus.best_nonce); end
    checks++; if (bus.best_hash !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL rst_hash: got %h expected ffffffff", bus.best_hash); end
    checks++; if (bus.match_count !== 9'd0) begin fails++; $display("[TB] FAIL rst_count: got %h expected 000", bus.match_count); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.mem_clk !== clk) begin fails++; $display("[TB] FAIL mem_clk: got %h expected %h", bus.mem_clk, clk); end
    checks++; if (bus.done !== 1'b1) begin fails++; $display("[TB] FAIL idle_done: got %h expected 1", bus.done); end
  endtask

  task automatic test_all_match();
    int cyc;
    int wc0;
    logic [31:0] exp_rec [0:2];
    for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 32'h8000_0000 + 32'(i * 16);
    exp_rec[0] = 32'h0000_0100; exp_rec[1] = 32'h8000_0000; exp_rec[2] = 32'h0000_0010;
    wc0 = write_count;
    run_scan(16'h0100, 16'h0200, 32'hFFFF_FFFF, 1'b0, cyc);
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL all_latency: got %0d expected 20", cyc); end
    checks++; if (bus.found !== 1'b1) begin fails++; $display("[TB] FAIL all_found: got %h expected 1", bus.found); end
    checks++; if (bus.match_count !== 9'd16) begin fails++; $display("[TB] FAIL all_count: got %0d expected 16", bus.match_count); end
    checks++; if (bus.best_nonce !== 8'd0) begin fails++; $display("[TB] FAIL all_nonce: got %0d expected 0", bus.best_nonce); end
    checks++; if (bus.best_hash !== 32'h8000_0000) begin fails++; $display("[TB] FAIL all_hash: got %h expected 80000000", bus.best_hash); end
    checks++; if (write_count - wc0 != 3) begin fails++; $display("[TB] FAIL all_nwrites: got %0d expected 3", write_count - wc0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wlog_addr[8'(wc0 + i)] !== 16'h0200 + 16'(i) || wlog_data[8'(wc0 + i)] !== exp_rec[i]) begin
        fails++;
        $display("[TB] FAIL all_rec%0d: got %h@%h expected %h@%h", i, wlog_data[8'(wc0 + i)], wlog_addr[8'(wc0 + i)], exp_rec[i], 16'h0200 + 16'(i));
      end
    end
  endtask

  task automatic test_ties();
    int cyc;
    int wc0;
    for (int i = 0; i < 16; i++) mem[16'h0300 + 16'(i)] = 32'hFFFF_0000;
    mem[16'h0305] = 32'h0000_1000;
    mem[16'h0309] = 32'h0000_1000;
    wc0 = write_count;
    run_scan(16'h0300, 16'h0400, 32'h0000_1000, 1'b0, cyc);
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL tie_latency: got %0d expected 20", cyc); end
    checks++; if (bus.found !== 1'b0) begin fails++; $display("[TB] FAIL tie_found: got %h expected 0", bus.found); end
    checks++; if (bus.match_count !== 9'd0) begin fails++; $display("[TB] FAIL tie_count: got %0d expected 0", bus.match_count); end
    checks++; if (bus.best_nonce !== 8'd5) begin fails++; $display("[TB] FAIL tie_nonce: got %0d expected 5", bus.best_nonce); end
    checks++; if (bus.best_hash !== 32'h0000_1000) begin fails++; $display("[TB] FAIL tie_hash: got %h expected 00001000", bus.best_hash); end
    checks++; if (wlog_data[8'(wc0)] !== 32'h0000_0005) begin fails++; $display("[TB] FAIL tie_rec0: got %h expected 00000005", wlog_data[8'(wc0)]); end
  endtask

  task automatic test_multi_match(input bit pulse);
    int cyc;
    int wc0;
    for (int i = 0; i < 16; i++) mem[16'h0500 + 16'(i)] = 32'hFFFF_FFFF;
    mem[16'h0503] = 32'h10; mem[16'h0507] = 32'h08; mem[16'h050F] = 32'h20;
    wc0 = write_count;
    run_scan(16'h0500, 16'h0600, 32'h0000_0021, pulse, cyc);
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL multi_latency(p=%0d): got %0d expected 20", pulse, cyc); end
    checks++; if (bus.match_count !== 9'd3) begin fails++; $display("[TB] FAIL multi_count: got %0d expected 3", bus.match_count); end
    checks++; if (bus.best_nonce !== 8'd7) begin fails++; $display("[TB] FAIL multi_nonce: got %0d expected 7", bus.best_nonce); end
    checks++; if (bus.found !== 1'b1) begin fails++; $display("[TB] FAIL multi_found: got %h expected 1", bus.found); end
    checks++; if (write_count - wc0 != 3) begin fails++; $display("[TB] FAIL multi_nwrites: got %0d expected 3", write_count - wc0); end
    checks++; if (wlog_data[8'(wc0)] !== 32'h107 || wlog_data[8'(wc0 + 1)] !== 32'h8 || wlog_data[8'(wc0 + 2)] !== 32'h3) begin
      fails++;
      $display("[TB] FAIL multi_rec: got %h %h %h expected 00000107 00000008 00000003", wlog_data[8'(wc0)], wlog_data[8'(wc0 + 1)], wlog_data[8'(wc0 + 2)]);
    end
    // Idle one cycle with start low so the next task begins from a clean IDLE.
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b1) begin fails++; $display("[TB] FAIL multi_idle: got %h expected 1", bus.done); end
  endtask

  task automatic test_addr_wrap();
    int cyc;
    int wc0;
    for (int i = 0; i < 16; i++) mem[16'hFFF8 + 16'(i)] = 32'h4000_0000 + 32'(16 - i);
    wc0 = write_count;
    run_scan(16'hFFF8, 16'hFFFE, 32'h4000_0004, 1'b0, cyc);
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL wrap_latency: got %0d expected 20", cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (addr_log[i] !== 16'hFFF8 + 16'(i)) begin fails++; $display("[TB] FAIL wrap_raddr%0d: got %h expected %h", i, addr_log[i], 16'hFFF8 + 16'(i)); end
    end
    checks++; if (addr_log[16] !== 16'h0007) begin fails++; $display("[TB] FAIL wrap_drain_addr: got %h expected 0007", addr_log[16]); end
    checks++; if (wlog_addr[8'(wc0)] !== 16'hFFFE || wlog_addr[8'(wc0 + 1)] !== 16'hFFFF || wlog_addr[8'(wc0 + 2)] !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL wrap_waddr: got %h %h %h expected fffe ffff 0000", wlog_addr[8'(wc0)], wlog_addr[8'(wc0 + 1)], wlog_addr[8'(wc0 + 2)]);
    end
    checks++; if (bus.best_nonce !== 8'd15) begin fails++; $display("[TB] FAIL wrap_nonce: got %0d expected 15", bus.best_nonce); end
    checks++; if (bus.best_hash !== 32'h4000_0001) begin fails++; $display("[TB] FAIL wrap_hash: got %h expected 40000001", bus.best_hash); end
    checks++; if (bus.match_count !== 9'd3) begin fails++; $display("[TB] FAIL wrap_count: got %0d expected 3", bus.match_count); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    int wc0;
    bus.hash_addr = 16'h0100; bus.result_addr = 16'h0700; bus.target = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bus.match_count !== 9'd5) begin fails++; $display("[TB] FAIL mid_count_before: got %0d expected 5", bus.match_count); end
    wc0 = write_count;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0) begin
      fails++; $display("[TB] FAIL mid_rst_ctrl: got done=%h we=%h addr=%h expected 1 0 0000", bus.done, bus.mem_we, bus.mem_addr);
    end
    checks++; if (bus.found !== 1'b0 || bus.match_count !== 9'd0 || bus.best_hash !== 32'hFFFF_FFFF || bus.best_nonce !== 8'd0) begin
      fails++; $display("[TB] FAIL mid_rst_out: got %h %0d %h %0d expected 0 0 ffffffff 0", bus.found, bus.match_count, bus.best_hash, bus.best_nonce);
    end
    repeat (3) @(posedge clk);
    checks++; if (write_count != wc0) begin fails++; $display("[TB] FAIL mid_rst_writes: got %0d expected %0d", write_count, wc0); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    wc0 = write_count;
    run_scan(16'h0100, 16'h0700, 32'hFFFF_FFFF, 1'b0, cyc);
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL mid_rerun_latency: got %0d expected 20", cyc); end
    checks++; if (bus.match_count !== 9'd16 || write_count - wc0 != 3) begin
      fails++; $display("[TB] FAIL mid_rerun: got count=%0d writes=%0d expected 16 3", bus.match_count, write_count - wc0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int wc0;
    bus.hash_addr = 16'h0100; bus.result_addr = 16'h0800; bus.target = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL b2b_first_latency: got %0d expected 20", cyc); end
    checks++; if (bus.match_count !== 9'd16) begin fails++; $display("[TB] FAIL b2b_first_count: got %0d expected 16", bus.match_count); end
    bus.target = 32'h0; bus.result_addr = 16'h0900;
    wc0 = write_count;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin fails++; $display("[TB] FAIL b2b_done_pulse: got %h expected 0", bus.done); end
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc != 20) begin fails++; $display("[TB] FAIL b2b_second_latency: got %0d expected 20", cyc); end
    checks++; if (bus.found !== 1'b0 || bus.match_count !== 9'd0) begin
      fails++; $display("[TB] FAIL b2b_target0: got found=%h count=%0d expected 0 0", bus.found, bus.match_count);
    end
    checks++; if (bus.best_hash !== 32'h8000_0000 || bus.best_nonce !== 8'd0) begin
      fails++; $display("[TB] FAIL b2b_best: got %h/%0d expected 80000000/0", bus.best_hash, bus.best_nonce);
    end
    checks++; if (wlog_addr[8'(wc0 + 2)] !== 16'h0902 || wlog_data[8'(wc0)] !== 32'h0) begin
      fails++; $display("[TB] FAIL b2b_rec: got %h@w2addr %h@w0data expected 0902 00000000", wlog_addr[8'(wc0 + 2)], wlog_data[8'(wc0)]);
    end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_ties();
    test_multi_match(1'b0);
    test_addr_wrap();
    test_reset_mid_scan();
    test_multi_match(1'b1);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nonce_result_scan.md
# nonce_result_scan

Post-processing stage downstream of the bitcoin hasher. Once the hasher has written its NUM_NONCES final H0 words to memory, this block reads them back and compares each against a 32-bit difficulty target. It reports the best (lowest) hash and its nonce index, plus whether and how many nonces met the target, then writes a 3-word result record to memory. It shares the same single-port synchronous memory and start/done handshake style as the hasher.

## Interface
- NUM_NONCES, 16, number of consecutive H0 words to scan; legal 1..256
- clk  in  1  clock; mem_clk is a copy
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- hash_addr  in  16  word address of H0 for nonce 0; latched on start
- result_addr  in  16  word address of the 3-word result record; latched on start
- target  in  32  unsigned threshold; a nonce matches iff hash < target; latched on start
- done  out  1  high exactly while in IDLE
- found  out  1  at least one nonce matched in the last completed scan
- best_nonce  out  8  index of the minimum hash in the last completed scan
- best_hash  out  32  minimum hash value in the last completed scan
- match_count  out  9  number of matching nonces in the last completed scan
- mem_clk  out  1  equals clk
- mem_we  out  1  write strobe
- mem_addr  out  16  word address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data, valid one cycle after its address is presented

## Operation
- States: IDLE, READ, DRAIN, WRITE.
- IDLE: done=1, mem_we=0, mem_addr=16'h0000. When start=1, the block:
  - latches hash_addr, result_addr and target;
  - sets best_hash=32'hFFFFFFFF, best_nonce=0, found=0, match_count=0, k=0;
  - moves to READ.
- READ, cycle k (k=0..NUM_NONCES-1):
  - mem_addr=hash_addr+k, mod 2^16; the address wraps at 16'hFFFF.
  - Data for address k-1 (k≥1) is on mem_read_data and is evaluated this cycle.
  - After k=NUM_NONCES-1, go to DRAIN.
- DRAIN: evaluate the data for the last address. mem_addr holds its last value. Go to WRITE.
- Evaluation of word d with index n:
  - If d < best_hash (strict, unsigned), best_hash←d and best_nonce←n. Ties keep the lower index.
  - If d < target (strict, unsigned), match_count←match_count+1 and found←1.
- WRITE: 3 cycles, w=0..2, mem_we=1, mem_addr=result_addr+w mod 2^16.
  - w=0 data = {23'b0, found, best_nonce}.
  - w=1 data = best_hash.
  - w=2 data = {23'b0, match_count}.
  - After w=2, go to IDLE.
- Outputs found, best_nonce, best_hash and match_count update only as described. They hold their values in IDLE until the next accepted start.
- start outside IDLE is ignored. target=0 never matches.
- best_nonce is 8 bits; NUM_NONCES=256 uses indices 0..255. match_count reaches 256 at most.

## Timing
- Reset values: state=IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, match_count=0.
- Reset is asynchronous at any point, including mid-READ or mid-WRITE:
  - all state and outputs take their reset values immediately;
  - a partially written record is left as-is.
- Let E0 be the edge that samples start in IDLE.
  - done falls after E0.
  - READ occupies NUM_NONCES cycles, DRAIN 1 cycle, WRITE 3 cycles.
  - done rises after edge E0+NUM_NONCES+4 (20 cycles for NUM_NONCES=16).
- Every output is registered. mem_write_data and mem_we change together on the edge that enters each WRITE cycle.
- No combinational path from mem_read_data to any output.
- Back-to-back runs: start held high through the return to IDLE is accepted on the first IDLE edge. done is high for one cycle in that case.

## Test plan
- Target above all hashes: H0 words 16'h0100+i = 32'h80000000+i×16, target=32'hFFFFFFFF.
  - Expect found=1, match_count=16, best_nonce=0, best_hash=32'h80000000.
  - Record {32'h00000100, 32'h80000000, 32'h00000010} at result_addr..+2; done 20 cycles after start.
- Boundary and ties: word 5 = 32'h00001000 and word 9 = 32'h00001000 (equal minima), others 32'hFFFF0000; target=32'h00001000.
  - Expect found=0, match_count=0 (equality does not match).
  - Expect best_nonce=5, best_hash=32'h00001000.
- Multiple matches: words 3, 7, 15 = 32'h10, 32'h08, 32'h20, others 32'hFFFFFFFF; target=32'h21.
  - Expect match_count=3, best_nonce=7, found=1.
- Address wrap: hash_addr=16'hFFF8, result_addr=16'hFFFE.
  - Expect reads at FFF8..FFFF then 0000..0007, and writes at FFFE, FFFF, 0000.
- Reset mid-scan: assert reset_n=0 during READ cycle 6.
  - Expect done=1, mem_we=0 and outputs at reset values within the same cycle; no memory writes.
  - A subsequent start completes normally.
- start pulses during READ and WRITE: ignored; the run completes in exactly 20 cycles with a single record written.
